sa_way_hit_select: RTL and testbench
====================================

# sa_way_hit_select

Registered tag-match and way-select stage of the 4-way set-associative cache. For one indexed set, it compares the request tag against every way's stored tag and qualifies each match with that way's valid bit. The qualified one-hot select picks the matching line and extracts the addressed data word. Output feeds the cache controller's hit/miss and read-data paths one cycle after the request.

## Interface
- `WAYS`, 4, number of ways (power of two, ≥2)
- `TAG_BITS`, 18, tag width
- `OFFSET_BITS`, 6, byte-offset width
- `LINE_SIZE_BITS`, 512, line payload width (8·2^OFFSET_BITS)
- `DATA_WIDTH`, 32, extracted word width (multiple of 8, ≤ LINE_SIZE_BITS)
- Reset rst, asynchronous, active-high; clock clk.
- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `i_valid`  in  1  lookup request this cycle
- `i_tag`  in  TAG_BITS  request tag
- `i_offset`  in  OFFSET_BITS  request byte offset
- `i_way_tags`  in  WAYS·TAG_BITS  stored tags, way w at [w·TAG_BITS +: TAG_BITS]
- `i_way_valid`  in  WAYS  stored valid bits
- `i_way_data`  in  WAYS·LINE_SIZE_BITS  stored lines, way w at [w·LINE_SIZE_BITS +: LINE_SIZE_BITS]
- `o_valid`  out  1  result valid
- `o_hit`  out  1  at least one qualified match
- `o_miss`  out  1  no qualified match (only with o_valid)
- `o_hit_onehot`  out  WAYS  qualified match vector
- `o_hit_way`  out  clog2(WAYS)  encoded hit way
- `o_multi_hit`  out  1  more than one qualified match (error)
- `o_line_data`  out  LINE_SIZE_BITS  selected line
- `o_word`  out  DATA_WIDTH  word at i_offset within selected line

## Operation
- Per way: `match[w] = (i_way_tags[w] == i_tag)`; `sel[w] = match[w] & i_way_valid[w]`. Invalid ways never hit, even on tag equality.
- Line select: `line = OR over w of (sel[w] ? data[w] : 0)`. Zero sel gives all-zero line. Multiple set bits give the bitwise OR of those lines, with o_multi_hit raised.
- `o_hit_way`: index of the lowest set bit of sel; 0 when sel is zero.
- Word: `line[8·i_offset +: DATA_WIDTH]`. Bytes beyond the line end read as zero; there is no wrap-around.
- `o_hit = |sel`; `o_miss = i_valid & ~|sel`; `o_multi_hit = popcount(sel) > 1`.
- Tag/valid/data inputs are sampled only in the cycle i_valid is high. No internal storage of the cache array.

## Timing
- Latency 1 cycle: request at edge N → outputs valid after edge N+1.
- i_valid low: o_valid, o_hit, o_miss and o_multi_hit register 0. o_hit_onehot, o_hit_way, o_line_data and o_word hold their last values.
- Back-to-back requests every cycle, full throughput; no stall or handshake.
- Reset clears every output to 0, immediately and asynchronously. A request in flight during reset is discarded.
- First request after reset deassertion is accepted on the next rising edge.

## Structure
- Shared package `sa_cache_pkg`: default WAYS/TAG_BITS/OFFSET_BITS/DATA_WIDTH, LINE_SIZE_BITS derivation, way-index width constant.
- One sub-module natural: `way_match` (tag equality AND valid → sel bit), instantiated WAYS times via generate. Mux, encoder and word extract stay in the top.

## Test plan
- Reset mid-stream: assert rst while o_valid=1 → all outputs 0 immediately; request one cycle after release → normal result.
- Single hit: tags {0x1,0x2,0x3,0x4}, valid 4'b1111, i_tag 0x3, i_offset 4, way2 line bytes 4..7 = 0xDEADBEEF → next cycle o_hit=1, o_hit_way=2, o_hit_onehot=4'b0100, o_word=0xDEADBEEF, o_line_data = way2 line.
- Tag match on invalid way: i_tag 0x3, valid 4'b1011 → o_miss=1, o_hit=0, o_line_data=0, o_word=0.
- Multi-hit: ways 1 and 3 both tag 0x5 and valid → o_multi_hit=1, o_hit_way=1, o_line_data = line1 | line3.
- Offset boundary: i_offset 62, DATA_WIDTH 32 → o_word[15:0] = line bytes 62..63, upper 16 bits 0. i_offset 60 → full bytes 60..63.
- Throughput/idle: requests on 3 consecutive cycles with different tags → 3 consecutive correct results. i_valid low next → o_valid=0 and the data outputs hold.

Source files
------------

// File: rtl/sa_way_hit_select_pkg.sv
// Shared constants for the set-associative cache tag-match / way-select stage.
package sa_cache_pkg;

  localparam int DEF_WAYS           = 4;
  localparam int DEF_TAG_BITS       = 18;
  localparam int DEF_OFFSET_BITS    = 6;
  localparam int DEF_LINE_SIZE_BITS = 8 * (1 << DEF_OFFSET_BITS);
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_WAY_IDX_BITS   = $clog2(DEF_WAYS);

endpackage : sa_cache_pkg

// File: rtl/sa_way_hit_select_if.sv
// Request/result bundle between the cache controller and the way-select stage.
interface sa_way_hit_select_if
  import sa_cache_pkg::*;
#(
  parameter int WAYS           = DEF_WAYS,
  parameter int TAG_BITS       = DEF_TAG_BITS,
  parameter int OFFSET_BITS    = DEF_OFFSET_BITS,
  parameter int LINE_SIZE_BITS = DEF_LINE_SIZE_BITS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WAY_IDX_BITS   = $clog2(WAYS)
) ();

  // request side
  logic                           i_valid;
  logic [TAG_BITS-1:0]            i_tag;
  logic [OFFSET_BITS-1:0]         i_offset;
  logic [WAYS*TAG_BITS-1:0]       i_way_tags;
  logic [WAYS-1:0]                i_way_valid;
  logic [WAYS*LINE_SIZE_BITS-1:0] i_way_data;

  // result side
  logic                           o_valid;
  logic                           o_hit;
  logic                           o_miss;
  logic [WAYS-1:0]                o_hit_onehot;
  logic [WAY_IDX_BITS-1:0]        o_hit_way;
  logic                           o_multi_hit;
  logic [LINE_SIZE_BITS-1:0]      o_line_data;
  logic [DATA_WIDTH-1:0]          o_word;

  modport master (
    output i_valid, i_tag, i_offset, i_way_tags, i_way_valid, i_way_data,
    input  o_valid, o_hit, o_miss, o_hit_onehot, o_hit_way, o_multi_hit,
           o_line_data, o_word
  );

  modport slave (
    input  i_valid, i_tag, i_offset, i_way_tags, i_way_valid, i_way_data,
    output o_valid, o_hit, o_miss, o_hit_onehot, o_hit_way, o_multi_hit,
           o_line_data, o_word
  );

endinterface : sa_way_hit_select_if

// File: rtl/sa_way_hit_select_way_match.sv
// One way's hit qualifier: stored tag equals request tag and the way is valid.
module way_match
  import sa_cache_pkg::*;
#(
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input  logic [TAG_BITS-1:0] way_tag_i,
  input  logic [TAG_BITS-1:0] req_tag_i,
  input  logic                way_valid_i,
  output logic                sel_o
);

  // an invalid way never hits, even when its stale tag happens to match
  assign sel_o = way_valid_i & (way_tag_i == req_tag_i);

endmodule : way_match

// File: rtl/sa_way_hit_select.sv
// Registered tag-match and way-select stage: qualifies per-way tag hits,
// muxes out the hitting line and extracts the addressed word, one cycle
// after the request.
module sa_way_hit_select
  import sa_cache_pkg::*;
#(
  parameter int WAYS           = DEF_WAYS,
  parameter int TAG_BITS       = DEF_TAG_BITS,
  parameter int OFFSET_BITS    = DEF_OFFSET_BITS,
  parameter int LINE_SIZE_BITS = DEF_LINE_SIZE_BITS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  sa_way_hit_select_if.slave bus
);

  localparam int WB = $clog2(WAYS);

  logic [WAYS-1:0]                      sel_s;
  logic [LINE_SIZE_BITS-1:0]            line_s;
  logic [WB-1:0]                        way_s;
  logic [WB:0]                          cnt_s;
  logic                                 multi_s;
  logic [LINE_SIZE_BITS+DATA_WIDTH-1:0] ext_s;
  logic [LINE_SIZE_BITS+DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0]                word_s;

  logic                      valid_q,  valid_d;
  logic                      hit_q,    hit_d;
  logic                      miss_q,   miss_d;
  logic                      multi_q,  multi_d;
  logic [WAYS-1:0]           onehot_q, onehot_d;
  logic [WB-1:0]             way_q,    way_d;
  logic [LINE_SIZE_BITS-1:0] line_q,   line_d;
  logic [DATA_WIDTH-1:0]     word_q,   word_d;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    way_match #(.TAG_BITS(TAG_BITS)) u_match (
      .way_tag_i   (bus.i_way_tags[w*TAG_BITS +: TAG_BITS]),
      .req_tag_i   (bus.i_tag),
      .way_valid_i (bus.i_way_valid[w]),
      .sel_o       (sel_s[w])
    );
  end

  // AND-OR line mux, hit count and lowest-index encoder over the qualified selects
  always_comb begin
    line_s = '0;
    cnt_s  = '0;
    way_s  = '0;
    for (int w = 0; w < WAYS; w++) begin
      line_s = line_s | (bus.i_way_data[w*LINE_SIZE_BITS +: LINE_SIZE_BITS]
                         & {LINE_SIZE_BITS{sel_s[w]}});
      cnt_s  = cnt_s + (WB+1)'(sel_s[w]);
    end
    // scan high to low so the lowest set way wins
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (sel_s[w]) begin
        way_s = w[WB-1:0];
      end else begin
        way_s = way_s;
      end
    end
    multi_s = (cnt_s > (WB+1)'(1));
  end

  // word extract: zero-extend past the line end so high offsets read zeros, no wrap
  always_comb begin
    ext_s     = {{DATA_WIDTH{1'b0}}, line_s};
    shifted_s = ext_s >> {bus.i_offset, 3'b000};
    word_s    = shifted_s[DATA_WIDTH-1:0];
  end

  // next-state: flags follow i_valid every cycle, data fields only update on a request
  always_comb begin
    valid_d  = bus.i_valid;
    hit_d    = bus.i_valid & (|sel_s);
    miss_d   = bus.i_valid & ~(|sel_s);
    multi_d  = bus.i_valid & multi_s;
    if (bus.i_valid) begin
      onehot_d = sel_s;
      way_d    = way_s;
      line_d   = line_s;
      word_d   = word_s;
    end else begin
      onehot_d = onehot_q;
      way_d    = way_q;
      line_d   = line_q;
      word_d   = word_q;
    end
  end

  // output registers, cleared asynchronously so an in-flight request is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      multi_q  <= 1'b0;
      onehot_q <= '0;
      way_q    <= '0;
      line_q   <= '0;
      word_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      multi_q  <= multi_d;
      onehot_q <= onehot_d;
      way_q    <= way_d;
      line_q   <= line_d;
      word_q   <= word_d;
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_hit        = hit_q;
  assign bus.o_miss       = miss_q;
  assign bus.o_multi_hit  = multi_q;
  assign bus.o_hit_onehot = onehot_q;
  assign bus.o_hit_way    = way_q;
  assign bus.o_line_data  = line_q;
  assign bus.o_word       = word_q;

endmodule : sa_way_hit_select

// File: tb/tb_sa_way_hit_select.sv
// Bench for sa_way_hit_select: directed scenarios plus randomized traffic
// against a byte-level behavioural model of the hit/select rules.
module tb_sa_way_hit_select;
  import sa_cache_pkg::*;

  localparam int W  = DEF_WAYS;
  localparam int TW = DEF_TAG_BITS;
  localparam int OB = DEF_OFFSET_BITS;
  localparam int L  = DEF_LINE_SIZE_BITS;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int WB = DEF_WAY_IDX_BITS;
  localparam int FW = 4 + W + WB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sa_way_hit_select_if bus ();

  sa_way_hit_select dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // request description
  logic [TW-1:0] tags_a [W];
  logic [L-1:0]  data_a [W];
  logic [W-1:0]  vmask;
  logic [TW-1:0] req_tag;
  logic [OB-1:0] req_off;

  // expected outputs and model's held data fields
  logic [FW-1:0] exp_flags;
  logic [L-1:0]  exp_line;
  logic [DW-1:0] exp_word;
  logic [W-1:0]  last_onehot;
  logic [WB-1:0] last_way;
  logic [L-1:0]  last_line;
  logic [DW-1:0] last_word;

  function automatic logic [L-1:0] rand_line();
    logic [L-1:0] r;
    for (int i = 0; i < L / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_req();
    logic [W-1:0]  s;
    logic [L-1:0]  ln;
    logic [DW-1:0] wd;
    int cnt;
    int first;
    int idx;
    s = '0; ln = '0; wd = '0; cnt = 0; first = -1;
    for (int w = 0; w < W; w++) begin
      if (vmask[w] && tags_a[w] == req_tag) begin
        s[w] = 1'b1;
        cnt++;
        ln = ln | data_a[w];
        if (first < 0) first = w;
      end
    end
    if (first < 0) first = 0;
    for (int k = 0; k < DW / 8; k++) begin
      idx = int'(req_off) + k;
      if (idx < L / 8) wd[k*8 +: 8] = ln[idx*8 +: 8];
      else             wd[k*8 +: 8] = 8'h00;
    end
    last_onehot = s;
    last_way    = first[WB-1:0];
    last_line   = ln;
    last_word   = wd;
    exp_flags   = {1'b1, (cnt > 0), (cnt == 0), (cnt > 1), s, last_way};
    exp_line    = ln;
    exp_word    = wd;
  endtask

  task automatic model_idle();
    exp_flags = {4'b0000, last_onehot, last_way};
    exp_line  = last_line;
    exp_word  = last_word;
  endtask

  task automatic model_reset();
    last_onehot = '0;
    last_way    = '0;
    last_line   = '0;
    last_word   = '0;
    exp_flags   = '0;
    exp_line    = '0;
    exp_word    = '0;
  endtask

  task automatic send_req();
    for (int w = 0; w < W; w++) begin
      bus.i_way_tags[w*TW +: TW] = tags_a[w];
      bus.i_way_data[w*L +: L]   = data_a[w];
    end
    bus.i_way_valid = vmask;
    bus.i_tag       = req_tag;
    bus.i_offset    = req_off;
    bus.i_valid     = 1'b1;
    model_req();
  endtask

  // idle cycle with scrambled array inputs: nothing may be sampled
  task automatic send_idle();
    bus.i_valid     = 1'b0;
    bus.i_tag       = TW'($urandom);
    bus.i_offset    = OB'($urandom);
    bus.i_way_valid = W'($urandom);
    for (int w = 0; w < W; w++) begin
      bus.i_way_tags[w*TW +: TW] = TW'($urandom);
      bus.i_way_data[w*L +: L]   = rand_line();
    end
    model_idle();
  endtask

  task automatic fill_random(input int tag_pool);
    for (int w = 0; w < W; w++) begin
      tags_a[w] = TW'($urandom_range(tag_pool - 1, 0));
      data_a[w] = rand_line();
    end
    vmask   = W'($urandom);
    req_tag = TW'($urandom_range(tag_pool - 1, 0));
    req_off = OB'($urandom);
  endtask

  task automatic fill_seq_tags();
    for (int w = 0; w < W; w++) begin
      tags_a[w] = TW'(w + 1);
      data_a[w] = rand_line();
    end
    vmask = 4'b1111;
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0;
    bus.i_tag = '0; bus.i_offset = '0; bus.i_way_valid = '0;
    bus.i_way_tags = '0; bus.i_way_data = '0;
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_vec++;
    if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
        || bus.o_word !== exp_word || bus.o_line_data !== exp_line) begin
      n_err++;
      $display("FAIL reset_init: flags got %b want %b, word got %h want %h",
               {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way},
               exp_flags, bus.o_word, exp_word);
    end
    rst = 1'b0;
    // a hit, so outputs are non-zero before the mid-stream reset
    fill_seq_tags();
    req_tag = TW'(2); req_off = OB'(8);
    send_req();
    @(negedge clk);
    n_vec++;
    if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
        || bus.o_word !== exp_word || bus.o_line_data !== exp_line) begin
      n_err++;
      $display("FAIL reset_prehit: flags got %b want %b, word got %h want %h",
               {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way},
               exp_flags, bus.o_word, exp_word);
    end
    // new request in flight when reset hits; it must be dropped
    fill_seq_tags();
    req_tag = TW'(4); req_off = OB'(0);
    send_req();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
        || bus.o_word !== exp_word || bus.o_line_data !== exp_line) begin
      n_err++;
      $display("FAIL reset_async: flags got %b want %b, word got %h want %h",
               {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way},
               exp_flags, bus.o_word, exp_word);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    fill_seq_tags();
    req_tag = TW'(1); req_off = OB'(12);
    send_req();
    @(negedge clk);
    n_vec++;
    if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
        || bus.o_word !== exp_word || bus.o_line_data !== exp_line) begin
      n_err++;
      $display("FAIL reset_after: flags got %b want %b, word got %h want %h",
               {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way},
               exp_flags, bus.o_word, exp_word);
    end
  endtask

  task automatic test_single_hit();
    fill_seq_tags();
    data_a[2][4*8 +: 32] = 32'hDEADBEEF;
    req_tag = TW'(3); req_off = OB'(4);
    send_req();
    @(negedge clk);
    n_vec++;
    if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
        || bus.o_hit_way !== 2'd2 || bus.o_hit_onehot !== 4'b0100) begin
      n_err++;
      $display("FAIL single_hit flags: got %b want %b",
               {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way}, exp_flags);
    end
    n_vec++;
    if (bus.o_word !== 32'hDEADBEEF || bus.o_line_data !== data_a[2]) begin
      n_err++;
      $display("FAIL single_hit data: word got %h want deadbeef", bus.o_word);
    end
  endtask

  task automatic test_invalid_way();
    fill_seq_tags();
    vmask = 4'b1011;
    req_tag = TW'(3); req_off = OB'(4);
    send_req();
    @(negedge clk);
    n_vec++;
    if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
        || bus.o_miss !== 1'b1 || bus.o_line_data !== '0 || bus.o_word !== '0) begin
      n_err++;
      $display("FAIL invalid_way: flags got %b want %b, word got %h want 0",
               {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way},
               exp_flags, bus.o_word);
    end
  endtask

  task automatic test_multi_hit();
    fill_seq_tags();
    tags_a[1] = TW'(5);
    tags_a[3] = TW'(5);
    req_tag = TW'(5); req_off = OB'(20);
    send_req();
    @(negedge clk);
    n_vec++;
    if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
        || bus.o_multi_hit !== 1'b1 || bus.o_hit_way !== 2'd1) begin
      n_err++;
      $display("FAIL multi_hit flags: got %b want %b",
               {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way}, exp_flags);
    end
    n_vec++;
    if (bus.o_line_data !== (data_a[1] | data_a[3]) || bus.o_word !== exp_word) begin
      n_err++;
      $display("FAIL multi_hit data: word got %h want %h", bus.o_word, exp_word);
    end
  endtask

  task automatic test_offset_boundary();
    for (int i = 0; i < 2; i++) begin
      fill_seq_tags();
      data_a[0][60*8 +: 32] = 32'hA1B2C3D4;
      req_tag = TW'(1);
      req_off = (i == 0) ? OB'(62) : OB'(60);
      send_req();
      @(negedge clk);
      n_vec++;
      if (bus.o_word !== exp_word || bus.o_word !== ((i == 0) ? 32'h0000A1B2 : 32'hA1B2C3D4)) begin
        n_err++;
        $display("FAIL offset_boundary off=%0d: word got %h want %h", req_off, bus.o_word, exp_word);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        fill_seq_tags();
        req_tag = TW'(i + 2);
        req_off = OB'($urandom);
        send_req();
      end else begin
        send_idle();
      end
      @(negedge clk);
      n_vec++;
      if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
          || bus.o_word !== exp_word || bus.o_line_data !== exp_line) begin
        n_err++;
        $display("FAIL back_to_back step %0d: flags got %b want %b, word got %h want %h", i,
                 {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way},
                 exp_flags, bus.o_word, exp_word);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) != 0) begin
        fill_random(6);
        send_req();
      end else begin
        send_idle();
      end
      @(negedge clk);
      n_vec++;
      if ({bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way} !== exp_flags
          || bus.o_word !== exp_word || bus.o_line_data !== exp_line) begin
        n_err++;
        $display("FAIL random iter %0d: flags got %b want %b, word got %h want %h", i,
                 {bus.o_valid, bus.o_hit, bus.o_miss, bus.o_multi_hit, bus.o_hit_onehot, bus.o_hit_way},
                 exp_flags, bus.o_word, exp_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_invalid_way();
    test_multi_hit();
    test_offset_boundary();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sa_way_hit_select
